pulse_freq_counter: RTL and testbench



---
 rtl/pulse_freq_counter.sv | 148 ++++++++++++++
 tb/tb_pulse_freq_counter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_freq_counter.sv
// pulse_freq_counter
// Counts rising edges of an asynchronous input over back-to-back gate windows
// of GATE_CYCLES clocks and latches the saturated count for a display stage.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst_n       asynchronous active-low reset
//   sig_in      asynchronous measured signal
//   enable      1 = run windows continuously, 0 = stop and drop the partial window
//   hold        1 = keep data/overflow frozen at window end (counting continues)
//   data        last latched edge count (saturating)
//   overflow    last latched window saturated
//   data_valid  one-cycle pulse when data/overflow update
//   gate_active high while measuring
//
// state   | meaning
// --------+-----------------------------------------------------------
// SETTLE  | 3 cycles after reset so prev holds a real sample; no counting
// IDLE    | waiting for enable, counters held at zero
// MEASURE | gate window running, edges accumulated
module pulse_freq_counter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  input  logic             hold,
  output logic [CNT_W-1:0] data,
  output logic             overflow,
  output logic             data_valid,
  output logic             gate_active
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    SETTLE  = 2'd0,
    IDLE    = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t           state;
  logic             s0;
  logic             s1;
  logic             prev;
  logic [1:0]       settle_cnt;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             sat;

  logic             rise;
  logic             at_max;
  logic             terminal;
  logic [CNT_W-1:0] edge_next;
  logic             sat_next;

  assign rise     = s1 & ~prev;
  assign at_max   = (edge_cnt == CNT_MAX);
  assign terminal = (gate_cnt == GATE_LAST);
  // Count including this cycle's rise, so a rise in the terminal cycle
  // still lands in the window being closed.
  assign edge_next = (rise && !at_max) ? edge_cnt + CNT_W'(1) : edge_cnt;
  assign sat_next  = sat | (rise & at_max);

  // Synchronizer and edge history run in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0   <= 1'b0;
      s1   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s0   <= sig_in;
      s1   <= s0;
      prev <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SETTLE;
      settle_cnt  <= 2'd0;
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      sat         <= 1'b0;
      data        <= '0;
      overflow    <= 1'b0;
      data_valid  <= 1'b0;
      gate_active <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        SETTLE: begin
          if (settle_cnt == 2'd2) begin
            settle_cnt <= 2'd0;
            state      <= IDLE;
          end else begin
            settle_cnt <= settle_cnt + 2'd1;
          end
        end
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat      <= 1'b0;
          if (enable) begin
            state       <= MEASURE;
            gate_active <= 1'b1;
          end
        end
        MEASURE: begin
          if (terminal) begin
            // Window close wins over a simultaneous enable drop.
            if (!hold) begin
              data       <= edge_next;
              overflow   <= sat_next;
              data_valid <= 1'b1;
            end
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            if (!enable) begin
              state       <= IDLE;
              gate_active <= 1'b0;
            end
          end else if (!enable) begin
            state       <= IDLE;
            gate_active <= 1'b0;
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            sat         <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= edge_next;
            sat      <= sat_next;
          end
        end
        default: begin
          state       <= SETTLE;
          gate_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_freq_counter.sv
module tb_pulse_freq_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig_in = 1'b0;
  logic        enable = 1'b0;
  logic        hold = 1'b0;
  logic [15:0] data;
  logic        overflow;
  logic        data_valid;
  logic        gate_active;

  logic        sig2 = 1'b0;
  logic        en2 = 1'b0;
  logic        hold2 = 1'b0;
  logic [3:0]  data2;
  logic        ovf2;
  logic        dv2;
  logic        ga2;

  int passed = 0;
  int total  = 0;
  int ph     = 0;
  int ph2    = 0;

  always #5 clk = ~clk;

  pulse_freq_counter #(.GATE_CYCLES(10), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable), .hold(hold),
    .data(data), .overflow(overflow), .data_valid(data_valid), .gate_active(gate_active)
  );

  pulse_freq_counter #(.GATE_CYCLES(40), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .sig_in(sig2), .enable(en2), .hold(hold2),
    .data(data2), .overflow(ovf2), .data_valid(dv2), .gate_active(ga2)
  );

  task automatic drive_sig(input int period);
    sig_in = ((ph % period) < (period / 2)) ? 1'b1 : 1'b0;
    ph++;
  endtask

  task automatic prerun(input int period, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_sig(period);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++; if (data !== 16'd0) $display("FAIL reset_data got %0d exp 0", data); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %0b exp 0", overflow); else passed++;
    total++; if (data_valid !== 1'b0) $display("FAIL reset_dv got %0b exp 0", data_valid); else passed++;
    total++; if (gate_active !== 1'b0) $display("FAIL reset_ga got %0b exp 0", gate_active); else passed++;
    total++; if (data2 !== 4'd0) $display("FAIL reset_data2 got %0d exp 0", data2); else passed++;
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      total++; if (gate_active !== 1'b0) $display("FAIL idle_ga i=%0d got %0b exp 0", i, gate_active); else passed++;
      total++; if (data_valid !== 1'b0) $display("FAIL idle_dv i=%0d got %0b exp 0", i, data_valid); else passed++;
    end
  endtask

  task automatic test_basic();
    logic exp_dv;
    prerun(5, 10);
    @(negedge clk);
    enable = 1'b1;
    drive_sig(5);
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      exp_dv = (i >= 11 && (i % 10) == 1);
      total++; if (gate_active !== 1'b1) $display("FAIL basic_ga i=%0d got %0b exp 1", i, gate_active); else passed++;
      total++; if (data_valid !== exp_dv) $display("FAIL basic_dv i=%0d got %0b exp %0b", i, data_valid, exp_dv); else passed++;
      if (exp_dv) begin
        total++; if (data !== 16'd2) $display("FAIL basic_data i=%0d got %0d exp 2", i, data); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL basic_ovf i=%0d got %0b exp 0", i, overflow); else passed++;
      end
      drive_sig(5);
    end
    enable = 1'b0;
    sig_in = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
  endtask

  task automatic test_sat();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sig2 = ~sig2;
    end
    @(negedge clk);
    en2 = 1'b1;
    sig2 = ~sig2;
    ph2 = 0;
    for (int i = 1; i <= 85; i++) begin
      @(negedge clk);
      if (i == 41) begin
        total++; if (dv2 !== 1'b1) $display("FAIL sat_dv got %0b exp 1", dv2); else passed++;
        total++; if (data2 !== 4'd15) $display("FAIL sat_data got %0d exp 15", data2); else passed++;
        total++; if (ovf2 !== 1'b1) $display("FAIL sat_ovf got %0b exp 1", ovf2); else passed++;
      end else if (i == 81) begin
        total++; if (dv2 !== 1'b1) $display("FAIL unsat_dv got %0b exp 1", dv2); else passed++;
        total++; if (data2 !== 4'd8) $display("FAIL unsat_data got %0d exp 8", data2); else passed++;
        total++; if (ovf2 !== 1'b0) $display("FAIL unsat_ovf got %0b exp 0", ovf2); else passed++;
      end else begin
        total++; if (dv2 !== 1'b0) $display("FAIL sat_dv_idle i=%0d got %0b exp 0", i, dv2); else passed++;
      end
      if (i < 30) sig2 = ~sig2;
      else begin
        sig2 = ((ph2 % 5) < 2) ? 1'b1 : 1'b0;
        ph2++;
      end
    end
    en2 = 1'b0;
  endtask

  task automatic test_terminal_rise();
    logic exp_dv;
    sig_in = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    enable = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      exp_dv = (i == 11 || i == 21);
      total++; if (data_valid !== exp_dv) $display("FAIL term_dv i=%0d got %0b exp %0b", i, data_valid, exp_dv); else passed++;
      if (i == 11) begin
        total++; if (data !== 16'd1) $display("FAIL term_data got %0d exp 1", data); else passed++;
      end
      if (i == 21) begin
        total++; if (data !== 16'd0) $display("FAIL term_next_data got %0d exp 0", data); else passed++;
      end
      if (i == 8) sig_in = 1'b1;
    end
    enable = 1'b0;
    sig_in = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
  endtask

  task automatic test_hold();
    logic exp_dv;
    prerun(5, 10);
    @(negedge clk);
    enable = 1'b1;
    drive_sig(5);
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      exp_dv = (i == 11 || i == 41);
      total++; if (data_valid !== exp_dv) $display("FAIL hold_dv i=%0d got %0b exp %0b", i, data_valid, exp_dv); else passed++;
      if (i >= 11 && i <= 40) begin
        total++; if (data !== 16'd2) $display("FAIL hold_data i=%0d got %0d exp 2", i, data); else passed++;
      end
      if (i == 41) begin
        total++; if (data !== 16'd1) $display("FAIL hold_release_data got %0d exp 1", data); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL hold_release_ovf got %0b exp 0", overflow); else passed++;
      end
      if (i == 12) hold = 1'b1;
      if (i == 32) hold = 1'b0;
      drive_sig((i < 12) ? 5 : 10);
    end
    enable = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
  endtask

  task automatic test_enable_drop();
    logic exp_ga;
    logic exp_dv;
    prerun(5, 10);
    @(negedge clk);
    enable = 1'b1;
    drive_sig(5);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      exp_ga = (i <= 6);
      total++; if (gate_active !== exp_ga) $display("FAIL drop_ga i=%0d got %0b exp %0b", i, gate_active, exp_ga); else passed++;
      total++; if (data_valid !== 1'b0) $display("FAIL drop_dv i=%0d got %0b exp 0", i, data_valid); else passed++;
      total++; if (data !== 16'd1) $display("FAIL drop_data i=%0d got %0d exp 1", i, data); else passed++;
      if (i == 6) enable = 1'b0;
      if (i == 20) enable = 1'b1;
      drive_sig(5);
    end
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      exp_dv = (j == 11);
      total++; if (gate_active !== 1'b1) $display("FAIL reen_ga j=%0d got %0b exp 1", j, gate_active); else passed++;
      total++; if (data_valid !== exp_dv) $display("FAIL reen_dv j=%0d got %0b exp %0b", j, data_valid, exp_dv); else passed++;
      total++; if (data !== ((j >= 11) ? 16'd2 : 16'd1)) $display("FAIL reen_data j=%0d got %0d", j, data); else passed++;
      drive_sig(5);
    end
    enable = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
  endtask

  task automatic test_terminal_drop();
    logic exp_dv;
    prerun(10, 10);
    @(negedge clk);
    enable = 1'b1;
    drive_sig(10);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      exp_dv = (i == 11);
      total++; if (data_valid !== exp_dv) $display("FAIL tdrop_dv i=%0d got %0b exp %0b", i, data_valid, exp_dv); else passed++;
      total++; if (gate_active !== (i <= 10)) $display("FAIL tdrop_ga i=%0d got %0b", i, gate_active); else passed++;
      total++; if (data !== ((i >= 11) ? 16'd1 : 16'd2)) $display("FAIL tdrop_data i=%0d got %0d", i, data); else passed++;
      if (i == 10) enable = 1'b0;
      drive_sig(10);
    end
  endtask

  task automatic test_reset_mid();
    logic exp_dv;
    prerun(5, 10);
    @(negedge clk);
    enable = 1'b1;
    drive_sig(5);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 11) begin
        total++; if (data !== 16'd2) $display("FAIL pre_rst_data got %0d exp 2", data); else passed++;
      end
      if (i < 15) drive_sig(5);
    end
    sig_in = 1'b1;
    rst_n = 1'b0;
    #1;
    total++; if (data !== 16'd0) $display("FAIL rst_mid_data got %0d exp 0", data); else passed++;
    total++; if (gate_active !== 1'b0) $display("FAIL rst_mid_ga got %0b exp 0", gate_active); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL rst_mid_ovf got %0b exp 0", overflow); else passed++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_dv = (k == 14);
      total++; if (gate_active !== (k >= 4)) $display("FAIL settle_ga k=%0d got %0b", k, gate_active); else passed++;
      total++; if (data_valid !== exp_dv) $display("FAIL settle_dv k=%0d got %0b exp %0b", k, data_valid, exp_dv); else passed++;
      total++; if (data !== 16'd0) $display("FAIL settle_data k=%0d got %0d exp 0", k, data); else passed++;
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sat();
    test_terminal_rise();
    test_hold();
    test_enable_drop();
    test_terminal_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
